ps2_key_tracker: RTL and testbench
==================================

Name: ps2_key_tracker

Overview:
- Consumes the byte stream from the PS/2 byte receiver: one 8-bit scan code per strobe.
- Maintains a registered 10-bit held-keys vector for the digit keys 0-9 on the main row, for use by the key-press detector and shifter logic downstream.
- Decodes make codes, break codes (F0 prefix) and the extended prefix (E0).
- Emits one-cycle press, release and repeat strobes, plus the index of the last key that changed.

Parameters:
- TIMEOUT_CYCLES, 100000, clocks allowed between a prefix byte and its follow-up byte before the FSM abandons the sequence.
- CNT_W, 17, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_code  in  8  scan-code byte; valid only while key_valid=1.
- key_valid  in  1  one-cycle strobe, one per received byte.
- clear  in  1  synchronous clear of all held keys and the FSM.
- keys  out  10  bit i=1 while digit key i is held.
- key_press  out  1  one-cycle pulse when a key bit goes 0->1.
- key_release  out  1  one-cycle pulse when a key bit goes 1->0.
- key_repeat  out  1  one-cycle pulse on a typematic make for an already-held key.
- last_key  out  4  index 0-9 of the key that produced the most recent strobe.

Behaviour:
- Reset (async, active-high): keys=0, all strobes=0, last_key=0, FSM=IDLE, counter=0.
- Digit scan codes map to bit indices as follows: 45->0, 16->1, 1E->2, 26->3, 25->4, 2E->5, 36->6, 3D->7, 3E->8, 46->9 (all hex). Every other code is "non-digit".
- Latency: all outputs are registered and update on the clock edge that samples key_valid=1. Strobes are high for exactly that one following cycle.
- Strobes are mutually exclusive. They are 0 in every cycle without a qualifying event.
- FSM states: IDLE, BRK, EXT, EXT_BRK.
- IDLE on valid byte:
  - F0 -> BRK.
  - E0 -> EXT.
  - Digit code with bit clear -> set bit, key_press=1, last_key=index.
  - Digit code with bit already set -> key_repeat=1, last_key=index, keys unchanged.
  - Non-digit -> ignored, stay IDLE.
- BRK on valid byte:
  - Digit code with bit set -> clear bit, key_release=1, last_key=index, -> IDLE.
  - Digit code with bit already clear -> no strobe, -> IDLE.
  - F0 -> stay BRK.
  - Any other byte -> IDLE, no effect.
- EXT on valid byte:
  - F0 -> EXT_BRK.
  - Any other byte -> IDLE. Extended codes never touch keys, even if equal to a digit code.
- EXT_BRK on valid byte: any byte -> IDLE, no effect.
- Timeout:
  - The counter resets to 0 on entry to any non-IDLE state and on every valid byte.
  - It increments each cycle while in a non-IDLE state with key_valid=0.
  - When it reaches TIMEOUT_CYCLES-1 the FSM returns to IDLE, with no strobe and keys unchanged.
- clear: takes priority over key_valid in the same cycle. keys=0, FSM=IDLE, counter=0, no strobes, last_key unchanged.
- Multiple keys may be held simultaneously. Bits are independent, and a release clears only its own bit.
- keys changes only via the make/break rules above. Consecutive bytes one cycle apart must be handled without loss.

Decomposition:
- Shared package ps2_pkg holds:
  - constants PS2_BREAK=F0 and PS2_EXT=E0;
  - the FSM state enum;
  - a function mapping scan code to {is_digit, index[3:0]}.
- One natural sub-module, ps2_digit_decode: combinational code -> {is_digit, index}, reusable by other keyboard blocks.
- The FSM, timeout counter and keys register stay in the top module.

Test Plan:
- Reset then stream 16 -> keys=0000000010, key_press pulse for 1 cycle, last_key=1; then F0,16 -> keys=0, key_release pulse, last_key=1.
- Stream 45, 46, 45 -> keys=1000000001. Press pulses on the first two bytes, key_repeat on the third, last_key=0.
- Stream E0,45 then E0,F0,45 -> keys stays 0, no strobes, FSM ends in IDLE.
- With keys bit 3 set, send F0 then idle TIMEOUT_CYCLES cycles (use TIMEOUT_CYCLES=8 in the bench), then 26 -> timeout returns the FSM to IDLE, and 26 gives key_repeat with bit 3 still set (not a release).
- Hold keys 2 and 5, assert clear together with key_valid on code 26 -> keys=0, no strobe. The next byte 26 -> key_press, keys=0000001000.
- Assert rst mid-sequence (after F0) -> all outputs 0 immediately. After release, 16 gives a press, not a break.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 scan-code constants, tracker FSM states and digit-key lookup
package ps2_pkg;
    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT = 8'hE0;
    typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
    function automatic logic [4:0] digit_map(input logic [7:0] code);
        case (code)
            8'h45: return {1'b1, 4'd0};
            8'h16: return {1'b1, 4'd1};
            8'h1E: return {1'b1, 4'd2};
            8'h26: return {1'b1, 4'd3};
            8'h25: return {1'b1, 4'd4};
            8'h2E: return {1'b1, 4'd5};
            8'h36: return {1'b1, 4'd6};
            8'h3D: return {1'b1, 4'd7};
            8'h3E: return {1'b1, 4'd8};
            8'h46: return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction
endpackage

// File: rtl/ps2_key_tracker_if.sv
// ps2_key_tracker_if: scan-code byte input and held-key/strobe outputs of the tracker
interface ps2_key_tracker_if;
    logic [7:0] key_code;
    logic key_valid;
    logic clear;
    logic [9:0] keys;
    logic key_press;
    logic key_release;
    logic key_repeat;
    logic [3:0] last_key;
    modport master (output key_code, key_valid, clear, input keys, key_press, key_release, key_repeat, last_key);
    modport slave (input key_code, key_valid, clear, output keys, key_press, key_release, key_repeat, last_key);
endinterface

// File: rtl/ps2_digit_decode.sv
// ps2_digit_decode: combinational main-row digit scan code to {is_digit, index}
module ps2_digit_decode
    import ps2_pkg::*;
(
    input  logic [7:0] code,
    output logic       is_digit,
    output logic [3:0] index
);
    assign {is_digit, index} = digit_map(code);
endmodule

// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: tracks held digit keys 0-9 from PS/2 make/break/extended byte stream
module ps2_key_tracker
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int CNT_W = 17
) (
    input logic clk,
    input logic rst,
    ps2_key_tracker_if.slave bus
);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [9:0] keys_q, keys_n;
    logic [3:0] last_q, last_n;
    logic press_q, press_n, release_q, release_n, repeat_q, repeat_n;
    logic is_digit;
    logic [3:0] idx;
    logic held;
    ps2_digit_decode u_dec (.code(bus.key_code), .is_digit(is_digit), .index(idx));
    assign held = keys_q[idx];
    always_comb begin
        state_n = state;
        cnt_n = '0;
        keys_n = keys_q;
        last_n = last_q;
        press_n = 1'b0;
        release_n = 1'b0;
        repeat_n = 1'b0;
        if (bus.clear) begin
            state_n = IDLE;
            keys_n = '0;
        end else if (bus.key_valid) begin
            case (state)
                IDLE: begin
                    state_n = bus.key_code == PS2_BREAK ? BRK : bus.key_code == PS2_EXT ? EXT : IDLE;
                    if (is_digit) begin
                        last_n = idx;
                        repeat_n = held;
                        press_n = !held;
                        keys_n[idx] = 1'b1;
                    end
                end
                BRK: begin
                    state_n = bus.key_code == PS2_BREAK ? BRK : IDLE;
                    if (is_digit && held) begin
                        keys_n[idx] = 1'b0;
                        release_n = 1'b1;
                        last_n = idx;
                    end
                end
                EXT: state_n = bus.key_code == PS2_BREAK ? EXT_BRK : IDLE;
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE) begin
            // an abandoned prefix must not swallow the next make code
            if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) state_n = IDLE;
            else cnt_n = cnt + 1'b1;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt <= '0;
            keys_q <= '0;
            last_q <= '0;
            press_q <= 1'b0;
            release_q <= 1'b0;
            repeat_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            keys_q <= keys_n;
            last_q <= last_n;
            press_q <= press_n;
            release_q <= release_n;
            repeat_q <= repeat_n;
        end
    end
    assign bus.keys = keys_q;
    assign bus.last_key = last_q;
    assign bus.key_press = press_q;
    assign bus.key_release = release_q;
    assign bus.key_repeat = repeat_q;
endmodule

// File: tb/tb_ps2_key_tracker.sv
// tb_ps2_key_tracker: directed byte sequences against hand-computed keys/strobes/last_key
module tb_ps2_key_tracker;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int passed = 0;
    ps2_key_tracker_if bus ();
    ps2_key_tracker #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask
    // strobes packed as {press, release, repeat}
    task automatic expect_out(input string tag, input logic [9:0] k, input logic [2:0] s, input logic [3:0] l);
        check({tag, ".keys"}, 16'(bus.keys), 16'(k));
        check({tag, ".strobes"}, 16'({bus.key_press, bus.key_release, bus.key_repeat}), 16'(s));
        check({tag, ".last"}, 16'(bus.last_key), 16'(l));
    endtask
    task automatic send(input logic [7:0] code);
        bus.key_code = code;
        bus.key_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.key_valid = 1'b0;
    endtask
    task automatic step(input string tag, input logic [7:0] code, input logic [9:0] k, input logic [2:0] s, input logic [3:0] l);
        send(code);
        expect_out(tag, k, s, l);
    endtask
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask
    initial begin
        bus.key_code = 8'h00;
        bus.key_valid = 1'b0;
        bus.clear = 1'b0;
        #12;
        expect_out("reset", 10'h000, 3'b000, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        step("make16", 8'h16, 10'h002, 3'b100, 4'd1);
        idle(1);
        expect_out("make16_after", 10'h002, 3'b000, 4'd1);
        step("brk_pfx", 8'hF0, 10'h002, 3'b000, 4'd1);
        step("brk16", 8'h16, 10'h000, 3'b010, 4'd1);
        step("make45", 8'h45, 10'h001, 3'b100, 4'd0);
        step("make46", 8'h46, 10'h201, 3'b100, 4'd9);
        step("rep45", 8'h45, 10'h201, 3'b001, 4'd0);
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        expect_out("clear", 10'h000, 3'b000, 4'd0);
        step("ext_pfx", 8'hE0, 10'h000, 3'b000, 4'd0);
        step("ext45", 8'h45, 10'h000, 3'b000, 4'd0);
        step("extbrk_e0", 8'hE0, 10'h000, 3'b000, 4'd0);
        step("extbrk_f0", 8'hF0, 10'h000, 3'b000, 4'd0);
        step("extbrk45", 8'h45, 10'h000, 3'b000, 4'd0);
        step("idle_make45", 8'h45, 10'h001, 3'b100, 4'd0);
        send(8'hF0);
        step("brk45", 8'h45, 10'h000, 3'b010, 4'd0);
        step("make26", 8'h26, 10'h008, 3'b100, 4'd3);
        send(8'hF0);
        idle(7);
        step("brk26_late", 8'h26, 10'h000, 3'b010, 4'd3);
        step("make26b", 8'h26, 10'h008, 3'b100, 4'd3);
        send(8'hF0);
        idle(8);
        expect_out("timeout", 10'h008, 3'b000, 4'd3);
        step("rep26_after_to", 8'h26, 10'h008, 3'b001, 4'd3);
        step("make1e", 8'h1E, 10'h00C, 3'b100, 4'd2);
        step("make2e", 8'h2E, 10'h02C, 3'b100, 4'd5);
        bus.clear = 1'b1;
        step("clear_valid", 8'h26, 10'h000, 3'b000, 4'd5);
        bus.clear = 1'b0;
        step("make26_post_clr", 8'h26, 10'h008, 3'b100, 4'd3);
        send(8'hF0);
        rst = 1'b1;
        #1;
        expect_out("async_rst", 10'h000, 3'b000, 4'd0);
        @(negedge clk);
        rst = 1'b0;
        step("make16_post_rst", 8'h16, 10'h002, 3'b100, 4'd1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
